// File: rtl/sik_pkg.sv
// Shared definitions for the SIK stack processor and its memory responder.
package sik_pkg;

    localparam int WORD_W = 16;

    // Responder FSM encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Major opcodes, shared with the processor core
    typedef enum logic [3:0] {
        OP_LIT   = 4'h0,
        OP_JMP   = 4'h1,
        OP_JZ    = 4'h2,
        OP_CALL  = 4'h3,
        OP_FUNC  = 4'h4
    } opcode_t;

    // No-argument function codes carried in OP_FUNC instructions
    localparam logic [7:0] Load  = 8'h01;
    localparam logic [7:0] Store = 8'h02;
    localparam logic [7:0] Push  = 8'h03;
    localparam logic [7:0] Pop   = 8'h04;
    localparam logic [7:0] Dup   = 8'h05;
    localparam logic [7:0] Swap  = 8'h06;
    localparam logic [7:0] Add   = 8'h07;
    localparam logic [7:0] Sub   = 8'h08;
    localparam logic [7:0] Ret   = 8'h09;

endpackage

// File: rtl/sik_mem_array.sv
// Single-port word RAM: synchronous write, read data follows the address.
// No reset; contents survive a responder reset.
module sik_mem_array
    import sik_pkg::*;
#(
    parameter int DEPTH_LOG2 = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Commit a write on the access edge
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sik_mem_responder.sv
// Timed, handshaked memory responder for the SIK core's memory port.
// One request in flight; access happens LATENCY cycles after acceptance and
// the result is held on the response port until the core takes it.
module sik_mem_responder
    import sik_pkg::*;
#(
    parameter int DEPTH_LOG2 = 16,
    parameter int LATENCY    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [15:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_we
);

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            cnt;
    logic                  accept;
    logic                  access;
    logic                  cap_we;
    logic [DEPTH_LOG2-1:0] cap_addr;
    logic [WORD_W-1:0]     cap_wdata;
    logic [WORD_W-1:0]     ram_rdata;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; RESP leaves only on a completed handshake
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded purely from registered state and counter
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        access    = (state == WAIT) && (cnt == 4'd0);
        accept    = (state == IDLE) && req_valid;
    end

    // Latency counter: loaded on accept, counts down to the access cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= 4'(LATENCY - 1);
        end else if ((state == WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Request capture; upper address bits are dropped so addresses wrap
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr[DEPTH_LOG2-1:0];
            cap_wdata <= req_wdata;
        end
    end

    // Response registers, updated only on the access cycle and then held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_rdata <= '0;
            rsp_we    <= 1'b0;
        end else if (access) begin
            rsp_rdata <= cap_we ? cap_wdata : ram_rdata;
            rsp_we    <= cap_we;
        end
    end

    sik_mem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .we   (access && cap_we),
        .addr (cap_addr),
        .wdata(cap_wdata),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_sik_mem_responder.sv
// Self-checking bench: instance 0 uses defaults (16 address bits, latency 2),
// instance 1 uses 8 address bits and latency 1.
module tb_sik_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rqv [2];
    logic        rqw [2];
    logic [15:0] rqa [2];
    logic [15:0] rqd [2];
    logic        rsr [2];
    logic        rdy [2];
    logic        vld [2];
    logic        rwe [2];
    logic [15:0] rdat [2];

    int pass_cnt = 0;
    int total = 0;
    int cyc = 0;

    sik_mem_responder dut_a (
        .clk(clk), .reset(reset),
        .req_valid(rqv[0]), .req_ready(rdy[0]), .req_we(rqw[0]),
        .req_addr(rqa[0]), .req_wdata(rqd[0]),
        .rsp_valid(vld[0]), .rsp_ready(rsr[0]),
        .rsp_rdata(rdat[0]), .rsp_we(rwe[0])
    );

    sik_mem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(rqv[1]), .req_ready(rdy[1]), .req_we(rqw[1]),
        .req_addr(rqa[1]), .req_wdata(rqd[1]),
        .rsp_valid(vld[1]), .rsp_ready(rsr[1]),
        .rsp_rdata(rdat[1]), .rsp_we(rwe[1])
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_busy [2];
    bit          m_vld [2];
    bit          m_we [2];
    int          m_age [2];
    logic [15:0] m_rdata [2];
    bit          c_we [2];
    logic [15:0] c_addr [2];
    logic [15:0] c_wdata [2];
    logic [15:0] mmem [int];

    function automatic int lat_of(int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int key_of(int k, logic [15:0] a);
        logic [15:0] m;
        m = (k == 0) ? 16'hFFFF : 16'h00FF;
        return k * 65536 + int'(a & m);
    endfunction

    initial forever begin
        @(posedge clk or posedge reset);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_busy[k] = 0; m_vld[k] = 0; m_we[k] = 0;
                m_age[k] = 0; m_rdata[k] = 16'h0000;
            end else if (!m_busy[k]) begin
                if (rqv[k]) begin
                    m_busy[k] = 1; m_age[k] = 0;
                    c_we[k] = rqw[k]; c_addr[k] = rqa[k]; c_wdata[k] = rqd[k];
                end
            end else if (m_vld[k]) begin
                if (rsr[k]) begin
                    m_busy[k] = 0; m_vld[k] = 0;
                end
            end else begin
                m_age[k]++;
                if (m_age[k] == lat_of(k)) begin
                    int key;
                    key = key_of(k, c_addr[k]);
                    if (c_we[k]) begin
                        mmem[key] = c_wdata[k];
                        m_rdata[k] = c_wdata[k];
                    end else begin
                        m_rdata[k] = mmem.exists(key) ? mmem[key] : 16'h0000;
                    end
                    m_we[k] = c_we[k];
                    m_vld[k] = 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("req_ready[%0d]", k), {15'd0, rdy[k]}, {15'd0, !m_busy[k]});
            chk($sformatf("rsp_valid[%0d]", k), {15'd0, vld[k]}, {15'd0, m_vld[k]});
            chk($sformatf("rsp_we[%0d]", k), {15'd0, rwe[k]}, {15'd0, m_we[k]});
            chk($sformatf("rsp_rdata[%0d]", k), rdat[k], m_rdata[k]);
        end
    end

    // ---------------- drivers ----------------
    task automatic do_req(input int k, input bit we, input logic [15:0] a, input logic [15:0] d);
        int n;
        n = 0;
        @(negedge clk);
        rqv[k] = 1'b1; rqw[k] = we; rqa[k] = a; rqd[k] = d;
        while (!rdy[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk($sformatf("req_accept_timeout[%0d]", k), {15'd0, rdy[k]}, 16'd1);
        @(negedge clk);
        rqv[k] = 1'b0;
    endtask

    task automatic wait_rsp(input int k, output logic [15:0] d);
        int n;
        n = 0;
        while (!vld[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk($sformatf("rsp_timeout[%0d]", k), {15'd0, vld[k]}, 16'd1);
        d = rdat[k];
        if (rsr[k]) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        int acc [4];
        logic [15:0] got [4];
        int nacc, nrsp, n;
        bit prev;

        for (int k = 0; k < 2; k++) begin
            rqv[k] = 0; rqw[k] = 0; rqa[k] = 0; rqd[k] = 0; rsr[k] = 1;
        end
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_req_ready", {15'd0, rdy[k]}, 16'd1);
            chk("reset_rsp_valid", {15'd0, vld[k]}, 16'd0);
            chk("reset_rsp_rdata", rdat[k], 16'h0000);
        end

        // Write 0xBEEF to 0x0010 with latency 2, then read it back
        do_req(0, 1'b1, 16'h0010, 16'hBEEF);
        chk("wr_ready_low", {15'd0, rdy[0]}, 16'd0);
        @(negedge clk);
        chk("wr_valid_not_yet", {15'd0, vld[0]}, 16'd0);
        @(negedge clk);
        chk("wr_valid", {15'd0, vld[0]}, 16'd1);
        chk("wr_rsp_we", {15'd0, rwe[0]}, 16'd1);
        chk("wr_rsp_rdata", rdat[0], 16'hBEEF);
        @(negedge clk);
        chk("wr_back_idle", {15'd0, rdy[0]}, 16'd1);
        do_req(0, 1'b0, 16'h0010, 16'h0000);
        wait_rsp(0, d);
        chk("rd_beef", d, 16'hBEEF);

        // Stalled read: response held 5 cycles, a competing request ignored
        do_req(0, 1'b1, 16'h0030, 16'h1111);
        wait_rsp(0, d);
        rsr[0] = 1'b0;
        do_req(0, 1'b0, 16'h0030, 16'h0000);
        wait_rsp(0, d);
        rqv[0] = 1'b1; rqw[0] = 1'b1; rqa[0] = 16'h0030; rqd[0] = 16'h9999;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {15'd0, vld[0]}, 16'd1);
            chk("stall_rdata", rdat[0], 16'h1111);
            @(negedge clk);
        end
        rqv[0] = 1'b0;
        rsr[0] = 1'b1;
        @(negedge clk);
        chk("stall_released", {15'd0, vld[0]}, 16'd0);
        do_req(0, 1'b0, 16'h0030, 16'h0000);
        wait_rsp(0, d);
        chk("stall_mem_unchanged", d, 16'h1111);

        // Latency 1: preload, then continuous reads of 0..3
        for (int i = 0; i < 4; i++) begin
            do_req(1, 1'b1, 16'(i), 16'hA000 + 16'(i));
            wait_rsp(1, d);
        end
        @(negedge clk);
        rqv[1] = 1'b1; rqw[1] = 1'b0; rqa[1] = 16'h0000;
        nacc = 0; nrsp = 0; n = 0;
        prev = rdy[1];
        while ((nacc < 4 || nrsp < 4) && n < 60) begin
            @(negedge clk);
            n++;
            if (prev && rqv[1]) begin
                acc[nacc] = cyc;
                nacc++;
                if (nacc < 4) rqa[1] = 16'(nacc);
                else rqv[1] = 1'b0;
            end
            if (vld[1] && nrsp < 4) begin
                got[nrsp] = rdat[1];
                nrsp++;
            end
            prev = rdy[1];
        end
        rqv[1] = 1'b0;
        chk("l1_accept_count", 16'(nacc), 16'd4);
        chk("l1_rsp_count", 16'(nrsp), 16'd4);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("l1_data%0d", j), got[j], 16'hA000 + 16'(j));
            if (j > 0) chk($sformatf("l1_spacing%0d", j), 16'(acc[j] - acc[j-1]), 16'd3);
        end

        // Address wrap with 8 address bits
        do_req(1, 1'b1, 16'h0105, 16'h1234);
        wait_rsp(1, d);
        do_req(1, 1'b0, 16'h0005, 16'h0000);
        wait_rsp(1, d);
        chk("wrap_read", d, 16'h1234);

        // Reset during WAIT aborts an uncommitted write
        do_req(0, 1'b1, 16'h0020, 16'h5555);
        wait_rsp(0, d);
        do_req(0, 1'b1, 16'h0020, 16'hAAAA);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("abort_rsp_valid", {15'd0, vld[0]}, 16'd0);
        chk("abort_req_ready", {15'd0, rdy[0]}, 16'd1);
        chk("abort_rsp_rdata", rdat[0], 16'h0000);
        #2 reset = 1'b0;
        do_req(0, 1'b0, 16'h0020, 16'h0000);
        wait_rsp(0, d);
        chk("abort_mem_kept", d, 16'h5555);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/sik_mem_responder.md
# sik_mem_responder

Memory-side responder for the SIK stack processor's data/instruction memory port. It accepts one request at a time from the core (read or write, 16-bit word address), waits a programmable access latency, and returns a response through a valid/ready handshake. It is the slave end of the core's memory interface and replaces the core's internal `mainmem` array with a timed, handshaked store.

## Interface
- `DEPTH_LOG2`, default 16: number of address bits decoded; memory holds 2^DEPTH_LOG2 16-bit words.
- `LATENCY`, default 2: cycles from request acceptance to the access being performed; legal range 1..15.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `req_valid`  input  1  core presents a request.
- `req_ready`  output  1  responder can accept a request.
- `req_we`  input  1  1 = write, 0 = read.
- `req_addr`  input  16  word address.
- `req_wdata`  input  16  write data.
- `rsp_valid`  output  1  response available.
- `rsp_ready`  input  1  core accepts the response.
- `rsp_rdata`  output  16  read data, or echoed write data for writes.
- `rsp_we`  output  1  echo of `req_we` for the transaction being answered.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. When `req_valid`&&`req_ready` are both high at a clock edge, capture `req_we`/`req_addr`/`req_wdata` and load the latency counter with LATENCY-1. Go to WAIT.
- WAIT: `req_ready`=0. The counter decrements each cycle. On the cycle it reaches 0, perform the access:
  - read: latch mem[addr] into `rsp_rdata`;
  - write: commit mem[addr] <= wdata and latch wdata into `rsp_rdata`.
  - Then go to RESP.
- With LATENCY=1, WAIT lasts exactly one cycle.
- RESP: `rsp_valid`=1. `rsp_rdata` and `rsp_we` are held stable. On `rsp_ready` high at the edge, go to IDLE. No other exit.
- Address: only `req_addr[DEPTH_LOG2-1:0]` is used; upper bits are ignored, so addresses wrap modulo the depth.
- Requests are never queued. `req_valid` asserted outside IDLE is ignored until IDLE, with no side effect.
- Exactly one write commit per accepted write.
- Reset (asynchronous, any state):
  - state=IDLE, counter=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_we`=0, `req_ready`=1 once decoded from IDLE.
  - Memory contents are not cleared.
  - A write aborted in WAIT before its commit cycle is not performed. A write that already committed stays committed.

## Timing
- `req_ready` = (state==IDLE); `rsp_valid` = (state==RESP). Both are decoded from registered state, with no combinational path from inputs.
- Request accepted at edge N: access performed at edge N+LATENCY, `rsp_valid` high after edge N+LATENCY.
- With `rsp_ready` tied high, the response handshakes at edge N+LATENCY+1 and the next request can be accepted at edge N+LATENCY+2. Peak throughput is one transaction per LATENCY+2 cycles.
- A read returns the memory value as of the access edge, including a write committed by the immediately preceding transaction.
- Arithmetic: the latency counter is 4 bits with no wrap; it is only decremented while nonzero in WAIT.

## Structure
- Shared package `sik_pkg`:
  - word width (16);
  - state encodings IDLE/WAIT/RESP;
  - opcode and no-arg function constants shared with the processor core (`Load` / `Store` / `Push` etc.), so core and responder agree on one definition.
- Sub-module `sik_mem_array`: single-port synchronous RAM with `clk`, `we`, `addr[DEPTH_LOG2-1:0]`, `wdata`, `rdata`. It is written and read only on the access cycle, and has no reset.
- The FSM, counter and response registers live in `sik_mem_responder`.

## Test plan
- Reset, then write 0xBEEF to addr 0x0010 with LATENCY=2: `req_ready` falls after accept, `rsp_valid` rises 2 cycles after accept with `rsp_we`=1 and `rsp_rdata`=0xBEEF. A following read of 0x0010 returns 0xBEEF.
- Back-to-back read with `rsp_ready` held low for 5 cycles: `rsp_valid` and `rsp_rdata` stay constant all 5 cycles. A second `req_valid` during that time is not accepted, and memory is unchanged.
- LATENCY=1, `rsp_ready`=1, continuous reads of 0x0000..0x0003: exactly one acceptance every 3 cycles, with data in order.
- DEPTH_LOG2=8: write 0x1234 to 0x0105, then read 0x0005, which returns 0x1234 (wrap).
- Accept a write of 0xAAAA to 0x0020 (old value 0x5555) and assert `reset` in WAIT before the commit edge: `rsp_valid`=0, state IDLE, and a subsequent read of 0x0020 returns 0x5555.
